imm_ext_stage: RTL and testbench

- Parametrised, pipelined successor to the combinational 16->32 sign extender.
- Sits between decode and execute. Takes an immediate field plus a mode and a sideband tag, and produces the extended/shifted operand one cycle later.
- Uses a valid/ready handshake with a 2-entry skid buffer, so in_ready is registered and the stage never drops data under back-pressure.
- Has a synchronous pipeline flush for branch/exception squash.

---
 rtl/imm_ext_pkg.sv | 15 +
 rtl/imm_ext_comb.sv | 29 ++
 rtl/imm_ext_stage.sv | 143 ++++++++++++++
 tb/tb_imm_ext_stage.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_ext_pkg.sv
// rtl/imm_ext_pkg.sv - shared mode encodings and default widths for the immediate extender
package imm_ext_pkg;

    localparam int IMM_IN_W  = 16;
    localparam int IMM_OUT_W = 32;
    localparam int IMM_TAG_W = 5;

    typedef enum logic [1:0] {
        IMM_ZERO   = 2'd0,
        IMM_SIGN   = 2'd1,
        IMM_UPPER  = 2'd2,
        IMM_BRANCH = 2'd3
    } imm_mode_e;

endpackage

// File: rtl/imm_ext_comb.sv
// rtl/imm_ext_comb.sv - combinational IN_W->OUT_W immediate extender (zero/sign/upper/branch)
module imm_ext_comb
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = IMM_IN_W,
    parameter int OUT_W = IMM_OUT_W
) (
    input  logic [IN_W-1:0]  data_i,
    input  imm_mode_e        mode_i,
    output logic [OUT_W-1:0] data_o
);

    logic [OUT_W-1:0] sext;

    assign sext = {{(OUT_W-IN_W){data_i[IN_W-1]}}, data_i};

    always_comb begin
        data_o = '0;
        case (mode_i)
            IMM_ZERO:   data_o = {{(OUT_W-IN_W){1'b0}}, data_i};
            IMM_SIGN:   data_o = sext;
            IMM_UPPER:  data_o = {data_i, {(OUT_W-IN_W){1'b0}}};
            // Bits shifted out of the top are simply dropped.
            IMM_BRANCH: data_o = {sext[OUT_W-3:0], 2'b00};
            default:    data_o = '0;
        endcase
    end

endmodule

// File: rtl/imm_ext_stage.sv
// rtl/imm_ext_stage.sv - pipelined immediate extender with 2-entry skid buffer; IMM_EXT_PERF_EN adds perf counters
module imm_ext_stage
    import imm_ext_pkg::*;
#(
    parameter int IN_W  = IMM_IN_W,
    parameter int OUT_W = IMM_OUT_W,
    parameter int TAG_W = IMM_TAG_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [TAG_W-1:0] out_tag
`ifdef IMM_EXT_PERF_EN
    ,
    output logic [31:0]      perf_stall_cnt,
    output logic [31:0]      perf_xfer_cnt
`endif
);

    generate
        if (OUT_W < IN_W + 2) begin : g_width_check
            $error("imm_ext_stage: OUT_W must be at least IN_W+2");
        end
    endgenerate

    logic [OUT_W-1:0] ext_data;
    logic             in_fire;
    logic             out_fire;

    logic             main_valid_q, main_valid_d;
    logic [OUT_W-1:0] main_data_q,  main_data_d;
    logic [TAG_W-1:0] main_tag_q,   main_tag_d;
    logic             skid_valid_q, skid_valid_d;
    logic [OUT_W-1:0] skid_data_q,  skid_data_d;
    logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;

    imm_ext_comb #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_comb (
        .data_i (in_data),
        .mode_i (imm_mode_e'(in_mode)),
        .data_o (ext_data)
    );

    assign in_ready  = !skid_valid_q;
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = main_valid_q && out_ready;
    assign out_valid = main_valid_q;
    assign out_data  = main_data_q;
    assign out_tag   = main_tag_q;

    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        main_tag_d   = main_tag_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_tag_d   = skid_tag_q;
        if (flush) begin
            // Payloads are left in place; only the valid bits are squashed.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || out_fire) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                main_tag_d   = skid_tag_q;
                skid_valid_d = in_fire;
                if (in_fire) begin
                    skid_data_d = ext_data;
                    skid_tag_d  = in_tag;
                end
            end else begin
                main_valid_d = in_fire;
                if (in_fire) begin
                    main_data_d = ext_data;
                    main_tag_d  = in_tag;
                end
            end
        end else if (in_fire) begin
            skid_valid_d = 1'b1;
            skid_data_d  = ext_data;
            skid_tag_d   = in_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_data_q  <= '0;
            main_tag_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_tag_q   <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            main_tag_q   <= main_tag_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_tag_q   <= skid_tag_d;
        end
    end

`ifdef IMM_EXT_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] xfer_cnt_q,  xfer_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        xfer_cnt_d  = xfer_cnt_q;
        if (main_valid_q && !out_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (out_fire && (xfer_cnt_q != 32'hFFFF_FFFF)) begin
            xfer_cnt_d = xfer_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            xfer_cnt_q  <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            xfer_cnt_q  <= xfer_cnt_d;
        end
    end

    assign perf_stall_cnt = stall_cnt_q;
    assign perf_xfer_cnt  = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_imm_ext_stage.sv
// tb/tb_imm_ext_stage.sv - self-checking bench for imm_ext_stage (vector table, corner sequences, random vs queue model)
module tb_imm_ext_stage;

    localparam int IN_W  = 16;
    localparam int OUT_W = 32;
    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
`ifdef IMM_EXT_PERF_EN
    logic [31:0]      perf_stall_cnt;
    logic [31:0]      perf_xfer_cnt;
`endif

    imm_ext_stage #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_mode   (in_mode),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
`ifdef IMM_EXT_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_xfer_cnt  (perf_xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       mode;
        logic [IN_W-1:0]  data;
        logic [TAG_W-1:0] tag;
        logic [OUT_W-1:0] exp_data;
    } vec_t;

    typedef struct {
        logic [OUT_W-1:0] data;
        logic [TAG_W-1:0] tag;
    } item_t;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [IN_W-1:0] d,
                         input logic [TAG_W-1:0] t);
        in_valid = v;
        in_mode  = m;
        in_data  = d;
        in_tag   = t;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 2'd0, '0, '0);
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    // Reference extension from arithmetic on the signed/unsigned value.
    function automatic logic [OUT_W-1:0] ref_ext(input logic [1:0] m, input logic [IN_W-1:0] d);
        longint u, s, r, mask;
        u = longint'(d);
        s = d[IN_W-1] ? u - (longint'(1) << IN_W) : u;
        mask = (longint'(1) << OUT_W) - 1;
        case (m)
            2'd0:    r = u;
            2'd1:    r = s;
            2'd2:    r = u * (longint'(1) << (OUT_W - IN_W));
            default: r = s * 4;
        endcase
        return OUT_W'(r & mask);
    endfunction

    vec_t  vecs[8];
    item_t q[$];

    initial begin
        vecs[0] = '{2'd1, 16'h8001, 5'd3,  32'hFFFF_8001};
        vecs[1] = '{2'd0, 16'h8001, 5'd4,  32'h0000_8001};
        vecs[2] = '{2'd2, 16'h1234, 5'd5,  32'h1234_0000};
        vecs[3] = '{2'd3, 16'hFFFF, 5'd6,  32'hFFFF_FFFC};
        vecs[4] = '{2'd3, 16'h7FFF, 5'd7,  32'h0001_FFFC};
        vecs[5] = '{2'd1, 16'h7FFF, 5'd8,  32'h0000_7FFF};
        vecs[6] = '{2'd0, 16'hFFFF, 5'd31, 32'h0000_FFFF};
        vecs[7] = '{2'd2, 16'hFFFF, 5'd0,  32'hFFFF_0000};

        // Reset state
        rst_n = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 2'd0, '0, '0);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_out_tag",   64'(out_tag),   64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        step();
        rst_n = 1'b1;
        step();

        // Single item, then empty
        out_ready = 1'b1;
        drive(1'b1, 2'd1, 16'h8001, 5'd3);
        step();
        chk("single_valid", 64'(out_valid), 64'd1);
        chk("single_data",  64'(out_data),  64'hFFFF_8001);
        chk("single_tag",   64'(out_tag),   64'd3);
        drive(1'b0, 2'd0, '0, '0);
        step();
        chk("single_drain", 64'(out_valid), 64'd0);

        // Back-to-back vector table
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, vecs[i].mode, vecs[i].data, vecs[i].tag);
            step();
            chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
            chk($sformatf("vec%0d_data", i),  64'(out_data),  64'(vecs[i].exp_data));
            chk($sformatf("vec%0d_tag", i),   64'(out_tag),   64'(vecs[i].tag));
        end
        drive(1'b0, 2'd0, '0, '0);
        step();
        chk("vec_drain", 64'(out_valid), 64'd0);

        // Back-pressure: A, B accepted, C held upstream
        out_ready = 1'b0;
        drive(1'b1, 2'd0, 16'h00AA, 5'd1);
        step();
        chk("bp_ready_after_a", 64'(in_ready), 64'd1);
        drive(1'b1, 2'd0, 16'h00BB, 5'd2);
        step();
        chk("bp_ready_after_b", 64'(in_ready), 64'd0);
        chk("bp_hold_a", 64'(out_data), 64'h0000_00AA);
        drive(1'b1, 2'd0, 16'h00CC, 5'd3);
        step();
        step();
        chk("bp_still_a",     64'(out_data), 64'h0000_00AA);
        chk("bp_still_a_tag", 64'(out_tag),  64'd1);
        chk("bp_c_held",      64'(in_ready), 64'd0);
        out_ready = 1'b1;
        step();
        chk("bp_emit_b", 64'(out_data), 64'h0000_00BB);
        chk("bp_ready_back", 64'(in_ready), 64'd1);
        step();
        chk("bp_emit_c", 64'(out_data), 64'h0000_00CC);
        chk("bp_emit_c_tag", 64'(out_tag), 64'd3);
        drive(1'b0, 2'd0, '0, '0);
        step();
        chk("bp_drain", 64'(out_valid), 64'd0);

        // Flush with both entries full and an offered input
        out_ready = 1'b0;
        drive(1'b1, 2'd0, 16'h0011, 5'd1);
        step();
        drive(1'b1, 2'd0, 16'h0022, 5'd2);
        step();
        drive(1'b1, 2'd0, 16'h0033, 5'd3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 2'd0, '0, '0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_ready", 64'(in_ready),  64'd1);
        out_ready = 1'b1;
        step();
        chk("flush_no_ghost", 64'(out_valid), 64'd0);

        // Flush discards a genuinely accepted input in the same cycle
        out_ready = 1'b0;
        drive(1'b1, 2'd0, 16'h0044, 5'd4);
        step();
        drive(1'b1, 2'd0, 16'h0055, 5'd5);
        flush = 1'b1;
        step();
        flush = 1'b0;
        drive(1'b0, 2'd0, '0, '0);
        out_ready = 1'b1;
        chk("flush_fire_valid", 64'(out_valid), 64'd0);
        step();
        chk("flush_fire_gone", 64'(out_valid), 64'd0);

        // Asynchronous reset mid-stream
        drive(1'b1, 2'd1, 16'hF00F, 5'd9);
        out_ready = 1'b0;
        step();
        chk("arst_pre_valid", 64'(out_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_data",  64'(out_data),  64'd0);
        chk("arst_tag",   64'(out_tag),   64'd0);
        chk("arst_ready", 64'(in_ready),  64'd1);
        drive(1'b0, 2'd0, '0, '0);
        step();
        rst_n = 1'b1;
        step();
        out_ready = 1'b1;
        drive(1'b1, 2'd3, 16'h8000, 5'd10);
        step();
        chk("arst_first_valid", 64'(out_valid), 64'd1);
        chk("arst_first_data",  64'(out_data),  64'hFFFE_0000);
        drive(1'b0, 2'd0, '0, '0);
        step();

`ifdef IMM_EXT_PERF_EN
        do_reset();
        chk("perf_rst_stall", 64'(perf_stall_cnt), 64'd0);
        chk("perf_rst_xfer",  64'(perf_xfer_cnt),  64'd0);
        drive(1'b1, 2'd0, 16'h0001, 5'd1);
        step();
        drive(1'b0, 2'd0, '0, '0);
        repeat (5) step();
        out_ready = 1'b1;
        drive(1'b1, 2'd0, 16'h0002, 5'd2);
        step();
        drive(1'b1, 2'd0, 16'h0003, 5'd3);
        step();
        drive(1'b0, 2'd0, '0, '0);
        step();
        chk("perf_stall", 64'(perf_stall_cnt), 64'd5);
        chk("perf_xfer",  64'(perf_xfer_cnt),  64'd3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("perf_flush_stall", 64'(perf_stall_cnt), 64'd5);
        chk("perf_flush_xfer",  64'(perf_xfer_cnt),  64'd3);
`endif

        // Random traffic against an occupancy-queue model
        do_reset();
        q.delete();
        for (int cyc = 0; cyc < 600; cyc++) begin
            logic       v, r, f;
            logic [1:0] m;
            logic [IN_W-1:0]  d;
            logic [TAG_W-1:0] t;
            bit in_fire, out_fire;
            chk("rnd_out_valid", 64'(out_valid), 64'(q.size() > 0));
            chk("rnd_in_ready",  64'(in_ready),  64'(q.size() < 2));
            if (q.size() > 0) begin
                chk("rnd_out_data", 64'(out_data), 64'(q[0].data));
                chk("rnd_out_tag",  64'(out_tag),  64'(q[0].tag));
            end
            v = 1'($urandom_range(0, 3) != 0);
            r = 1'($urandom_range(0, 2) != 0);
            f = 1'($urandom_range(0, 40) == 0);
            m = 2'($urandom_range(0, 3));
            d = IN_W'($urandom);
            t = TAG_W'($urandom);
            drive(v, m, d, t);
            out_ready = r;
            flush = f;
            in_fire  = v && (q.size() < 2);
            out_fire = r && (q.size() > 0);
            if (f) begin
                q.delete();
            end else begin
                if (out_fire) void'(q.pop_front());
                if (in_fire) q.push_back('{ref_ext(m, d), t});
            end
            step();
        end
        flush = 1'b0;
        drive(1'b0, 2'd0, '0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
